// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and stall controller for the 5-stage pipeline.
// It drives the enables of the IF/ID and ID/EX pipeline registers.
//
// Outputs:
//   - pc_write / if_id_write : front-end load enables.
//   - if_id_flush            : squash the instruction fetched behind a taken branch.
//   - ctrl_out               : control word entering ID/EX. This is the
//                              decoder word, or NOP_CTRL for a bubble.
//   - mdu_busy               : a multiply/divide sequence is holding the front end.
//
// Priority in RUN: taken branch > load-use hazard > MDU start.
// After an MDU issue the front end is frozen for exactly MDU_LAT-1 cycles.
// MDU_LAT is legal over 2..16.
//
// Handshake: none. This block only qualifies register enables.
// An enable of 0 means "hold"; an enable of 1 means "load at the next rising edge".
//
// Optional build macro HAZ_PERF_CNT_EN adds the saturating performance
// counters stall_cycles and flush_count.
module pipe_hazard_ctrl #(
  parameter int unsigned          CTRL_W   = 14,
  parameter logic [CTRL_W-1:0]    NOP_CTRL = 14'h0001,
  parameter int unsigned          MDU_LAT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        if_id_rs,
  input  logic [4:0]        if_id_rt,
  input  logic              if_id_uses_rt,
  input  logic [4:0]        id_ex_rt,
  input  logic              id_ex_mem_read,
  input  logic              id_mdu_start,
  input  logic              branch_taken,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              mdu_busy,
  output logic              dbg_state
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_count
`endif
);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_e;

  // The issue cycle is spent in RUN.
  // The remaining MDU_LAT-1 held cycles run cnt from MDU_LAT-2 down to 0.
  localparam logic [3:0] CNT_INIT = 4'(MDU_LAT - 2);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu;

  // Load-use hazard: the load in EX writes a register that ID is about to read.
  // Register 0 is hard-wired, so it never creates a hazard.
  always_comb begin
    lu = id_ex_mem_read && (id_ex_rt != 5'd0) &&
         ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
  end

  // Next-state and output decode.
  // While reset is low, all outputs are forced to their reset values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    mdu_busy    = 1'b0;
    ctrl_out    = ctrl_in;
    if (reset) begin
      unique case (state_q)
        RUN: begin
          if (branch_taken) begin
            // Squash the wrong-path instruction.
            // Any MDU start in ID is on the wrong path too.
            if_id_flush = 1'b1;
            ctrl_out    = NOP_CTRL;
          end else if (lu) begin
            // One bubble. By the next cycle the load has left EX.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ctrl_out    = NOP_CTRL;
          end else if (id_mdu_start) begin
            // The MDU instruction itself enters ID/EX.
            // The freeze begins next cycle.
            state_d = MDU_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
        MDU_WAIT: begin
          // EX holds only bubbles here, so branch and lu cannot legally assert.
          mdu_busy    = 1'b1;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ctrl_out    = NOP_CTRL;
          if (cnt_q == 4'd0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbg_state = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cycles_q, flush_count_q;

  // Saturating event counters: stalled cycles and flushed cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= 16'd0;
      flush_count_q  <= 16'd0;
    end else begin
      if (!pc_write && (stall_cycles_q != 16'hFFFF)) begin
        stall_cycles_q <= stall_cycles_q + 16'd1;
      end
      if (if_id_flush && (flush_count_q != 16'hFFFF)) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule
